control_unit: RTL

//  Moore FSM that sequences the 8-bit data_path: fetch, decode, execute. Drives every

---
 rtl/control_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// Moore sequencer for the 8-bit data_path: fetch, decode, execute.
// All strobes come from registered state only. They are forced to zero while Reset is low.
module control_unit (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] IR,
    input  logic [3:0] CCR_Result,
    output logic       IR_Load,
    output logic       MAR_Load,
    output logic       PC_Load,
    output logic       PC_Inc,
    output logic       A_Load,
    output logic       B_Load,
    output logic       CCR_Load,
    output logic [2:0] ALU_Sel,
    output logic [1:0] Bus1_Sel,
    output logic [1:0] Bus2_Sel,
    output logic       write
);
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_INC = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_DEC = 3'b011;

    localparam logic [1:0] BUS1_PC   = 2'b00;
    localparam logic [1:0] BUS1_A    = 2'b01;
    localparam logic [1:0] BUS1_B    = 2'b10;
    localparam logic [1:0] BUS2_ALU  = 2'b00;
    localparam logic [1:0] BUS2_BUS1 = 2'b01;
    localparam logic [1:0] BUS2_MEM  = 2'b10;

    typedef enum logic [4:0] {
        S_F0, S_F1, S_F2, S_D3,
        S_LDI4, S_LDI5, S_LDI6,
        S_LDD4, S_LDD5, S_LDD6, S_LDD7, S_LDD8,
        S_ST4, S_ST5, S_ST6, S_ST7,
        S_ALU4,
        S_BT4, S_BT5, S_BT6,
        S_BN4, S_BN5
    } state_t;

    state_t     state_q, state_d;
    logic       sel_b_q, sel_b_d;
    logic [2:0] alu_q, alu_d;
    logic       taken;

    // The operand register and ALU code are captured at decode so execute states depend only on flops.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= S_F0;
            sel_b_q <= 1'b0;
            alu_q   <= ALU_ADD;
        end else begin
            state_q <= state_d;
            sel_b_q <= sel_b_d;
            alu_q   <= alu_d;
        end
    end

    always_comb begin
        taken = 1'b0;
        case (IR)
            8'h20:   taken = 1'b1;
            8'h21:   taken = CCR_Result[3];
            8'h22:   taken = !CCR_Result[3];
            8'h23:   taken = CCR_Result[2];
            8'h24:   taken = !CCR_Result[2];
            8'h25:   taken = CCR_Result[1];
            8'h27:   taken = CCR_Result[0];
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sel_b_d = sel_b_q;
        alu_d   = alu_q;
        case (state_q)
            S_F0: state_d = S_F1;
            S_F1: state_d = S_F2;
            S_F2: state_d = S_D3;
            S_D3: begin
                state_d = S_F0;
                case (IR)
                    8'h86: begin state_d = S_LDI4; sel_b_d = 1'b0; end
                    8'h88: begin state_d = S_LDI4; sel_b_d = 1'b1; end
                    8'h87: begin state_d = S_LDD4; sel_b_d = 1'b0; end
                    8'h89: begin state_d = S_LDD4; sel_b_d = 1'b1; end
                    8'h96: begin state_d = S_ST4;  sel_b_d = 1'b0; end
                    8'h97: begin state_d = S_ST4;  sel_b_d = 1'b1; end
                    8'h42: begin state_d = S_ALU4; sel_b_d = 1'b0; alu_d = ALU_ADD; end
                    8'h43: begin state_d = S_ALU4; sel_b_d = 1'b0; alu_d = ALU_SUB; end
                    8'h44: begin state_d = S_ALU4; sel_b_d = 1'b0; alu_d = ALU_INC; end
                    8'h45: begin state_d = S_ALU4; sel_b_d = 1'b0; alu_d = ALU_DEC; end
                    8'h46: begin state_d = S_ALU4; sel_b_d = 1'b1; alu_d = ALU_INC; end
                    8'h47: begin state_d = S_ALU4; sel_b_d = 1'b1; alu_d = ALU_DEC; end
                    8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h27:
                        state_d = taken ? S_BT4 : S_BN4;
                    default: state_d = S_F0;
                endcase
            end
            S_LDI4: state_d = S_LDI5;
            S_LDI5: state_d = S_LDI6;
            S_LDD4: state_d = S_LDD5;
            S_LDD5: state_d = S_LDD6;
            S_LDD6: state_d = S_LDD7;
            S_LDD7: state_d = S_LDD8;
            S_ST4:  state_d = S_ST5;
            S_ST5:  state_d = S_ST6;
            S_ST6:  state_d = S_ST7;
            S_BT4:  state_d = S_BT5;
            S_BT5:  state_d = S_BT6;
            S_BN4:  state_d = S_BN5;
            default: state_d = S_F0;
        endcase
    end

    always_comb begin
        IR_Load  = 1'b0;
        MAR_Load = 1'b0;
        PC_Load  = 1'b0;
        PC_Inc   = 1'b0;
        A_Load   = 1'b0;
        B_Load   = 1'b0;
        CCR_Load = 1'b0;
        ALU_Sel  = ALU_ADD;
        Bus1_Sel = BUS1_PC;
        Bus2_Sel = BUS2_ALU;
        write    = 1'b0;
        if (Reset) begin
            case (state_q)
                S_F0, S_LDI4, S_LDD4, S_ST4, S_BT4: begin
                    Bus1_Sel = BUS1_PC;
                    Bus2_Sel = BUS2_BUS1;
                    MAR_Load = 1'b1;
                end
                S_F1, S_LDI5, S_LDD5, S_ST5, S_BN5: PC_Inc = 1'b1;
                S_F2: begin
                    Bus2_Sel = BUS2_MEM;
                    IR_Load  = 1'b1;
                end
                S_LDI6, S_LDD8: begin
                    Bus2_Sel = BUS2_MEM;
                    A_Load   = !sel_b_q;
                    B_Load   = sel_b_q;
                end
                S_LDD6, S_ST6: begin
                    Bus2_Sel = BUS2_MEM;
                    MAR_Load = 1'b1;
                end
                S_ST7: begin
                    Bus1_Sel = sel_b_q ? BUS1_B : BUS1_A;
                    write    = 1'b1;
                end
                S_ALU4: begin
                    Bus1_Sel = sel_b_q ? BUS1_B : BUS1_A;
                    Bus2_Sel = BUS2_ALU;
                    ALU_Sel  = alu_q;
                    A_Load   = !sel_b_q;
                    B_Load   = sel_b_q;
                    CCR_Load = 1'b1;
                end
                S_BT6: begin
                    Bus2_Sel = BUS2_MEM;
                    PC_Load  = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
